apb_master_arbiter: RTL and testbench

Sequences and shares the bridge's single APB master port among NREQ internal requesters (AHB-side write/read pipelines, configuration engine). Arbitrates round-robin, decodes the target slave select, drives the APB SETUP/ACCESS phases, absorbs PREADY wait states and aborts hung slaves with a timeout. Sits between the AHB request capture logic and the APB pins.

---
 rtl/apb_master_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one APB master port among NREQ requesters.
// Decodes the slave select from addr[AW-1:AW-6], absorbs wait states and aborts hung slaves.
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              hresetn,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_req_write,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_wdata,
  output logic [NREQ-1:0]   o_done,
  output logic [DW-1:0]     o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic [2:0]        o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [AW-1:0]     o_paddr,
  output logic [DW-1:0]     o_pwdata,
  input  logic [DW-1:0]     i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  localparam int GW = (NREQ > 2) ? 2 : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [GW-1:0]   ONE_G     = GW'(1);
  localparam logic [GW-1:0]   LAST_G    = GW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_N     = NREQ'(1);
  localparam logic [TW-1:0]   ONE_T     = TW'(1);
  localparam logic [TW-1:0]   TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_gnt;
  logic [TW-1:0]   r_tcnt;
  logic [2:0]      r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;
  logic [NREQ-1:0] r_done;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic            r_busy;

  logic [GW-1:0]   w_gnt;
  logic [GW-1:0]   w_idx;
  logic            w_found;
  logic            w_any;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [2:0]      w_sel;
  logic            w_tmo;

  logic [GW-1:0]   w_rr_n;
  logic [GW-1:0]   w_gnt_n;
  logic [TW-1:0]   w_tcnt_n;
  logic [2:0]      w_psel_n;
  logic            w_penable_n;
  logic            w_pwrite_n;
  logic [AW-1:0]   w_paddr_n;
  logic [DW-1:0]   w_pwdata_n;
  logic [NREQ-1:0] w_done_n;
  logic [DW-1:0]   w_rdata_n;
  logic            w_err_n;
  logic            w_busy_n;

  assign w_any   = |i_req;
  assign w_addr  = i_req_addr[w_gnt*AW +: AW];
  assign w_wdata = i_req_wdata[w_gnt*DW +: DW];
  assign w_tmo   = (r_tcnt == TCNT_LAST);

  // Round-robin pick: first set request at or above r_rr_ptr, wrapping.
  always_comb begin
    w_gnt   = r_rr_ptr;
    w_idx   = r_rr_ptr;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end else begin
        w_found = w_found;
      end
      if (w_idx == LAST_G) begin
        w_idx = '0;
      end else begin
        w_idx = w_idx + ONE_G;
      end
    end
  end

  // Slave select decode from the top six address bits.
  always_comb begin
    case (w_addr[AW-1 -: 6])
      6'b100000: w_sel = 3'b001;
      6'b100001: w_sel = 3'b010;
      6'b100010: w_sel = 3'b100;
      default:   w_sel = 3'b000;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_n = (w_sel != 3'b000) ? ST_SETUP : ST_RESP;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_SETUP:  w_state_n = ST_ACCESS;
      ST_ACCESS: begin
        if (i_pready || w_tmo) begin
          w_state_n = ST_RESP;
        end else begin
          w_state_n = ST_ACCESS;
        end
      end
      ST_RESP:   w_state_n = ST_IDLE;
      default:   w_state_n = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration state.
  always_comb begin
    w_rr_n      = r_rr_ptr;
    w_gnt_n     = r_gnt;
    w_tcnt_n    = r_tcnt;
    w_psel_n    = r_psel;
    w_penable_n = r_penable;
    w_pwrite_n  = r_pwrite;
    w_paddr_n   = r_paddr;
    w_pwdata_n  = r_pwdata;
    w_done_n    = '0;
    w_rdata_n   = r_rdata;
    w_err_n     = r_err;
    w_busy_n    = (w_state_n != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_n = w_gnt;
          // A decode error completes without touching the APB pins.
          if (w_sel != 3'b000) begin
            w_psel_n    = w_sel;
            w_penable_n = 1'b0;
            w_pwrite_n  = i_req_write[w_gnt];
            w_paddr_n   = w_addr;
            w_pwdata_n  = w_wdata;
          end else begin
            w_done_n  = ONE_N << w_gnt;
            w_rdata_n = '0;
            w_err_n   = 1'b1;
          end
        end else begin
          w_gnt_n = r_gnt;
        end
      end
      ST_SETUP: begin
        w_penable_n = 1'b1;
        w_tcnt_n    = '0;
      end
      ST_ACCESS: begin
        if (i_pready) begin
          w_psel_n    = 3'b000;
          w_penable_n = 1'b0;
          w_done_n    = ONE_N << r_gnt;
          w_rdata_n   = r_pwrite ? '0 : i_prdata;
          w_err_n     = i_pslverr;
        end else if (w_tmo) begin
          w_psel_n    = 3'b000;
          w_penable_n = 1'b0;
          w_done_n    = ONE_N << r_gnt;
          w_rdata_n   = '0;
          w_err_n     = 1'b1;
        end else begin
          w_tcnt_n = r_tcnt + ONE_T;
        end
      end
      ST_RESP: begin
        if (r_gnt == LAST_G) begin
          w_rr_n = '0;
        end else begin
          w_rr_n = r_gnt + ONE_G;
        end
      end
      default: begin
        w_psel_n    = 3'b000;
        w_penable_n = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_tcnt    <= '0;
      r_psel    <= 3'b000;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rr_ptr  <= w_rr_n;
      r_gnt     <= w_gnt_n;
      r_tcnt    <= w_tcnt_n;
      r_psel    <= w_psel_n;
      r_penable <= w_penable_n;
      r_pwrite  <= w_pwrite_n;
      r_paddr   <= w_paddr_n;
      r_pwdata  <= w_pwdata_n;
      r_done    <= w_done_n;
      r_rdata   <= w_rdata_n;
      r_err     <= w_err_n;
      r_busy    <= w_busy_n;
    end
  end

  assign o_done      = r_done;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
  assign o_busy      = r_busy;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed transfers queue expected responses and
// APB phases; independent monitors compare them when done pulses / ACCESS phases appear.
module tb_apb_master_arbiter;
  localparam int NREQ = 2, AW = 32, DW = 32, TIMEOUT = 16;
  localparam logic [31:0] A0 = 32'h8000_0010, A1 = 32'h8400_0004;
  localparam logic [31:0] A2 = 32'h8800_0000, ABAD = 32'h9000_0000;

  logic clk = 1'b0;
  logic hresetn;
  logic [NREQ-1:0] i_req, i_req_write, o_done;
  logic [NREQ*AW-1:0] i_req_addr;
  logic [NREQ*DW-1:0] i_req_wdata;
  logic [DW-1:0] o_rsp_rdata, o_pwdata, i_prdata;
  logic o_rsp_err, o_busy, o_penable, o_pwrite, i_pready, i_pslverr;
  logic [2:0] o_psel;
  logic [AW-1:0] o_paddr;

  apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .hresetn(hresetn), .i_req(i_req), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .o_done(o_done),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_busy(o_busy), .o_psel(o_psel),
    .o_penable(o_penable), .o_pwrite(o_pwrite), .o_paddr(o_paddr), .o_pwdata(o_pwdata),
    .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr));

  always #5 clk = ~clk;

  typedef struct { logic [1:0] mask; logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic [2:0] psel; logic pwrite; logic [31:0] paddr; logic [31:0] pwdata; int nacc; } apb_t;
  rsp_t rsp_q[$];
  apb_t apb_q[$];

  int total = 0, bad = 0, cyc = 0;
  int slv_wait = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic slv_err = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_rsp(input logic [1:0] m, input logic [31:0] rd, input logic e, input int c);
    rsp_t t;
    t.mask = m; t.rdata = rd; t.err = e; t.cyc = c;
    rsp_q.push_back(t);
  endtask

  task automatic exp_apb(input logic [2:0] ps, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int n);
    apb_t t;
    t.psel = ps; t.pwrite = w; t.paddr = a; t.pwdata = d; t.nacc = n;
    apb_q.push_back(t);
  endtask

  task automatic set_rq(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    i_req_write[i] = w;
    i_req_addr[i*AW +: AW] = a;
    i_req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!o_busy) return;
    end
    total++; bad++;
    $display("FAIL wait_idle: busy still high after 50 cycles");
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_done != 2'b00) return;
    end
    total++; bad++;
    $display("FAIL wait_done: no done pulse within %0d cycles", budget);
  endtask

  // One transfer from requester i; expected timing follows from the sample edge k.
  task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int wt, input logic [31:0] rd, input logic er, input logic [2:0] ps);
    logic [1:0] m;
    int k;
    wait_idle();
    slv_wait = wt; slv_rdata = rd; slv_err = er;
    set_rq(i, w, a, d);
    m = 2'b01;
    m = m << i;
    i_req = m;
    k = cyc + 1;
    if (ps == 3'b000) begin
      exp_rsp(m, 32'h0, 1'b1, k);
    end else if (wt >= TIMEOUT) begin
      exp_rsp(m, 32'h0, 1'b1, k + 1 + TIMEOUT);
      exp_apb(ps, w, a, d, TIMEOUT);
    end else begin
      exp_rsp(m, w ? 32'h0 : rd, er, k + 2 + wt);
      exp_apb(ps, w, a, d, wt + 1);
    end
    wait_done(TIMEOUT + 20);
    i_req = 2'b00;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model: pready after slv_wait ACCESS cycles; garbage data/error while not ready.
  initial begin
    int acc;
    acc = 0;
    i_pready = 1'b0; i_prdata = 32'h0; i_pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (hresetn && o_penable) begin
        i_pready = (acc >= slv_wait);
        acc++;
      end else begin
        i_pready = 1'b0;
        acc = 0;
      end
      i_prdata  = i_pready ? slv_rdata : 32'hFFFF_FFFF;
      i_pslverr = i_pready ? slv_err : 1'b1;
    end
  end

  // Monitor: response scoreboard plus APB phase/stability checks.
  initial begin
    rsp_t e; apb_t a; apb_t cap;
    int run, gap;
    logic seen, prev_pen;
    logic [2:0] prev_psel;
    run = 0; gap = 0; seen = 1'b0; prev_pen = 1'b0; prev_psel = 3'b000;
    forever begin
      @(negedge clk);
      if (!hresetn) begin
        run = 0; gap = 0; seen = 1'b0; prev_pen = 1'b0; prev_psel = 3'b000;
      end else begin
        if (o_done != 2'b00) begin
          if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got %0b expected none (cycle %0d)", o_done, cyc);
          end else begin
            e = rsp_q.pop_front();
            chk("done_mask", 64'(o_done), 64'(e.mask));
            chk("rsp_rdata", 64'(o_rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
        if (o_penable) begin
          if (run == 0) begin
            chk("setup_phase", {62'h0, prev_psel == o_psel, prev_pen}, 64'h2);
            cap.psel = o_psel; cap.pwrite = o_pwrite; cap.paddr = o_paddr; cap.pwdata = o_pwdata;
          end else begin
            chk("apb_stable", 64'({o_psel, o_pwrite, o_paddr, o_pwdata} ==
                                  {cap.psel, cap.pwrite, cap.paddr, cap.pwdata}), 64'h1);
          end
          run++;
        end else if (run > 0) begin
          if (apb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_access: got psel %0b expected none", cap.psel);
          end else begin
            a = apb_q.pop_front();
            chk("psel", 64'(cap.psel), 64'(a.psel));
            chk("pwrite", 64'(cap.pwrite), 64'(a.pwrite));
            chk("paddr", 64'(cap.paddr), 64'(a.paddr));
            chk("pwdata", 64'(cap.pwdata), 64'(a.pwdata));
            chk("access_len", 64'(run), 64'(a.nacc));
          end
          run = 0;
        end
        if (o_psel != 3'b000 && prev_psel == 3'b000) begin
          if (seen) chk("psel_gap", 64'(gap >= 2), 64'h1);
          seen = 1'b1;
          gap = 0;
        end else if (o_psel == 3'b000) begin
          gap++;
        end
        prev_psel = o_psel;
        prev_pen = o_penable;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k;
    hresetn = 1'b0;
    i_req = 2'b00; i_req_write = 2'b00; i_req_addr = '0; i_req_wdata = '0;
    #12;
    chk("reset_outs", {23'h0, o_done, o_rsp_rdata, o_rsp_err, o_busy, o_psel, o_penable, o_pwrite}, 64'h0);
    chk("reset_paddr", 64'(o_paddr), 64'h0);
    chk("reset_pwdata", 64'(o_pwdata), 64'h0);
    @(negedge clk);
    hresetn = 1'b1;

    // zero-wait read, then write with three wait states
    xfer(0, 1'b0, A0, 32'hCAFE_0000, 0, 32'hDEAD_BEEF, 1'b0, 3'b001);
    chk("busy_in_resp", 64'(o_busy), 64'h1);
    xfer(1, 1'b1, A1, 32'h1234_5678, 3, 32'h5555_AAAA, 1'b0, 3'b010);

    // both requesters held: grants 0,1,0,1 every four cycles
    wait_idle();
    slv_wait = 0; slv_rdata = 32'h0BAD_CAFE; slv_err = 1'b0;
    set_rq(0, 1'b0, A2, 32'hAAAA_0000);
    set_rq(1, 1'b1, A1, 32'hBBBB_1111);
    i_req = 2'b11;
    k = cyc + 1;
    for (int r = 0; r < 2; r++) begin
      exp_rsp(2'b01, 32'h0BAD_CAFE, 1'b0, k + 2 + 8 * r);
      exp_rsp(2'b10, 32'h0, 1'b0, k + 6 + 8 * r);
      exp_apb(3'b100, 1'b0, A2, 32'hAAAA_0000, 1);
      exp_apb(3'b010, 1'b1, A1, 32'hBBBB_1111, 1);
    end
    repeat (4) wait_done(20);
    i_req = 2'b00;

    // decode error, then slave error on a valid read
    xfer(0, 1'b0, ABAD, 32'h0, 0, 32'h1111_2222, 1'b0, 3'b000);
    xfer(1, 1'b0, A0, 32'h7777_0000, 1, 32'h0BAD_F00D, 1'b1, 3'b001);

    // hung slave times out, next request served normally
    xfer(0, 1'b0, A1, 32'h0, 1000, 32'h3333_4444, 1'b0, 3'b010);
    xfer(1, 1'b1, A0, 32'h9876_5432, 0, 32'h0, 1'b0, 3'b001);

    // reset during ACCESS of requester 1's grant; restart from rr_ptr=0
    xfer(0, 1'b0, A2, 32'h0, 0, 32'h0101_0101, 1'b0, 3'b100);
    wait_idle();
    slv_wait = 1000; slv_err = 1'b0;
    set_rq(0, 1'b0, A0, 32'h1111_1111);
    set_rq(1, 1'b0, A2, 32'h2222_2222);
    i_req = 2'b11;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o_penable) break;
    end
    chk("rr_grant_before_reset", 64'(o_paddr), 64'(A2));
    #2 hresetn = 1'b0;
    #1;
    chk("midreset_outs", {23'h0, o_done, o_rsp_rdata, o_rsp_err, o_busy, o_psel, o_penable, o_pwrite}, 64'h0);
    chk("midreset_paddr", 64'(o_paddr), 64'h0);
    chk("midreset_pwdata", 64'(o_pwdata), 64'h0);
    slv_wait = 0; slv_rdata = 32'h5A5A_0001;
    @(negedge clk);
    hresetn = 1'b1;
    k = cyc + 1;
    exp_rsp(2'b01, 32'h5A5A_0001, 1'b0, k + 2);
    exp_rsp(2'b10, 32'h5A5A_0001, 1'b0, k + 6);
    exp_apb(3'b001, 1'b0, A0, 32'h1111_1111, 1);
    exp_apb(3'b100, 1'b0, A2, 32'h2222_2222, 1);
    repeat (2) wait_done(20);
    i_req = 2'b00;

    repeat (6) @(negedge clk);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'h0);
    chk("apb_q_drained", 64'(apb_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
